// File: rtl/ahbapbbridge_err_pkg.sv
// Shared types and constants for the AHB-Lite to APB bridge with error/timeout support.
package ahbapbbridge_err_pkg;

    typedef struct packed {
        int XLEN;
        int PA_BITS;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{XLEN: 32, PA_BITS: 34};

    typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS, APB_ERR2} apbstate_t;

    localparam int APB_TIMEOUT_DEFAULT = 256;

    // APB PPROT = {instruction, nonsecure, privileged}; AHB HPROT[0]=data, HPROT[1]=privileged
    function automatic logic [2:0] hprot_to_pprot(input logic [3:0] hprot);
        return {~hprot[0], 1'b0, hprot[1]};
    endfunction

endpackage

// File: rtl/ahbapbbridge_err_apbrespmux.sv
// PSEL-indexed response mux: picks PREADY/PSLVERR/PRDATA of the selected slave.
module ahbapbbridge_err_apbrespmux #(
    parameter int PERIPHS = 2,
    parameter int XLEN    = 32
) (
    input  logic [PERIPHS-1:0]           psel,
    input  logic [PERIPHS-1:0]           pready,
    input  logic [PERIPHS-1:0]           pslverr,
    input  logic [PERIPHS-1:0][XLEN-1:0] prdata,
    output logic                         sel_ready,
    output logic                         sel_err,
    output logic [XLEN-1:0]              sel_rdata
);

    // Later iterations overwrite earlier ones, so the highest set index wins.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < PERIPHS; i++) begin
            if (psel[i]) begin
                sel_ready = pready[i];
                sel_err   = pslverr[i];
                sel_rdata = prdata[i];
            end
        end
    end

endmodule

// File: rtl/ahbapbbridge_err.sv
// AHB-Lite to APB bridge: PSLVERR -> two-cycle AHB ERROR, PREADY watchdog, PPROT from HPROT.
module ahbapbbridge_err
    import ahbapbbridge_err_pkg::*;
#(
    parameter cvw_t P       = CVW_DEFAULT,
    parameter int   PERIPHS = 2,
    parameter int   TIMEOUT = APB_TIMEOUT_DEFAULT
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [PERIPHS-1:0]               HSEL,
    input  logic [P.PA_BITS-1:0]             HADDR,
    input  logic [P.XLEN-1:0]                HWDATA,
    input  logic [P.XLEN/8-1:0]              HWSTRB,
    input  logic                             HWRITE,
    input  logic [1:0]                       HTRANS,
    input  logic [3:0]                       HPROT,
    input  logic                             HREADY,
    output logic [P.XLEN-1:0]                HRDATA,
    output logic                             HRESP,
    output logic                             HREADYOUT,
    output logic                             PCLK,
    output logic                             PRESETn,
    output logic [PERIPHS-1:0]               PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [31:0]                      PADDR,
    output logic [P.XLEN-1:0]                PWDATA,
    output logic [P.XLEN/8-1:0]              PSTRB,
    output logic [2:0]                       PPROT,
    input  logic [PERIPHS-1:0]               PREADY,
    input  logic [PERIPHS-1:0]               PSLVERR,
    input  logic [PERIPHS-1:0][P.XLEN-1:0]   PRDATA
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    apbstate_t           state_q, state_d;
    logic [PERIPHS-1:0]  psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [31:0]         paddr_q, paddr_d;
    logic [2:0]          pprot_q, pprot_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic                start, go, timeout_hit;
    logic                sel_ready, sel_err;
    logic [P.XLEN-1:0]   sel_rdata;

    ahbapbbridge_err_apbrespmux #(.PERIPHS(PERIPHS), .XLEN(P.XLEN)) u_respmux (
        .psel      (psel_q),
        .pready    (PREADY),
        .pslverr   (PSLVERR),
        .prdata    (PRDATA),
        .sel_ready (sel_ready),
        .sel_err   (sel_err),
        .sel_rdata (sel_rdata)
    );

    assign start       = HREADY & HTRANS[1] & (|HSEL);
    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pprot_d   = pprot_q;
        cnt_d     = cnt_q;
        go        = 1'b0;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        case (state_q)
            APB_IDLE: go = start;
            APB_SETUP: begin
                HREADYOUT = 1'b0;
                state_d   = APB_ACCESS;
                penable_d = 1'b1;
            end
            APB_ACCESS: begin
                if (sel_ready && !sel_err) begin
                    HRDATA    = sel_rdata;
                    go        = start;
                    state_d   = APB_IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                end else if (sel_ready || timeout_hit) begin
                    // First half of the AHB ERROR response; bus still stalled.
                    HREADYOUT = 1'b0;
                    HRESP     = 1'b1;
                    state_d   = APB_ERR2;
                    psel_d    = '0;
                    penable_d = 1'b0;
                end else begin
                    HREADYOUT = 1'b0;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
            end
            APB_ERR2: begin
                HRESP   = 1'b1;
                go      = start;
                state_d = APB_IDLE;
            end
            default: state_d = APB_IDLE;
        endcase
        if (go) begin
            state_d   = APB_SETUP;
            psel_d    = HSEL;
            penable_d = 1'b0;
            pwrite_d  = HWRITE;
            paddr_d   = HADDR[31:0];
            pprot_d   = hprot_to_pprot(HPROT);
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= APB_IDLE;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pprot_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pprot_q   <= pprot_d;
            cnt_q     <= cnt_d;
        end
    end

    assign PCLK    = clk;
    assign PRESETn = ~reset;
    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PPROT   = pprot_q;
    assign PWDATA  = HWDATA;
    assign PSTRB   = pwrite_q ? HWSTRB : '0;

    generate
        if (P.PA_BITS > 32) begin : g_unused_addr
            logic unused_haddr;
            assign unused_haddr = ^HADDR[P.PA_BITS-1:32];
        end
    endgenerate
    logic unused_ctl;
    assign unused_ctl = ^{HTRANS[0], HPROT[3:2]};

endmodule

// File: tb/tb_ahbapbbridge_err.sv
// Directed bench for ahbapbbridge_err: read, wait-state write, PSLVERR, timeout, back-to-back, reset.
module tb_ahbapbbridge_err;
    import ahbapbbridge_err_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         HSEL;
    logic [33:0]        HADDR;
    logic [31:0]        HWDATA;
    logic [3:0]         HWSTRB;
    logic               HWRITE;
    logic [1:0]         HTRANS;
    logic [3:0]         HPROT;
    logic               HREADY;
    logic [31:0]        HRDATA;
    logic               HRESP;
    logic               HREADYOUT;
    logic               PCLK;
    logic               PRESETn;
    logic [1:0]         PSEL;
    logic               PENABLE;
    logic               PWRITE;
    logic [31:0]        PADDR;
    logic [31:0]        PWDATA;
    logic [3:0]         PSTRB;
    logic [2:0]         PPROT;
    logic [1:0]         PREADY;
    logic [1:0]         PSLVERR;
    logic [1:0][31:0]   PRDATA;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Single-slave bus: the bus-wide HREADY is the bridge's own HREADYOUT.
    assign HREADY = HREADYOUT;

    ahbapbbridge_err #(.P(CVW_DEFAULT), .PERIPHS(2), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
        .HWSTRB(HWSTRB), .HWRITE(HWRITE), .HTRANS(HTRANS), .HPROT(HPROT),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .HREADYOUT(HREADYOUT),
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    // Advance to just after the next rising edge; inputs set after this settle before checks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        HSEL = 2'b00; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus_idle();
        HADDR = '0; HWDATA = '0; HWSTRB = '0; HPROT = '0;
        PREADY = 2'b00; PSLVERR = 2'b00;
        PRDATA[0] = 32'h1111_1111; PRDATA[1] = 32'hDEAD_BEEF;
        tick(); tick(); #2;
        checks++; if (PRESETn !== 1'b0) begin failures++; $display("FAIL rst_presetn got=%b exp=0", PRESETn); end
        reset = 1'b0;
        tick(); #2;
        checks++; if (PSEL !== 2'b00) begin failures++; $display("FAIL rst_psel got=%b exp=00", PSEL); end
        checks++; if (PENABLE !== 1'b0) begin failures++; $display("FAIL rst_penable got=%b exp=0", PENABLE); end
        checks++; if (PWRITE !== 1'b0) begin failures++; $display("FAIL rst_pwrite got=%b exp=0", PWRITE); end
        checks++; if (PADDR !== 32'h0) begin failures++; $display("FAIL rst_paddr got=%h exp=0", PADDR); end
        checks++; if (PPROT !== 3'b000) begin failures++; $display("FAIL rst_pprot got=%b exp=000", PPROT); end
        checks++; if (HRESP !== 1'b0) begin failures++; $display("FAIL rst_hresp got=%b exp=0", HRESP); end
        checks++; if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL rst_hreadyout got=%b exp=1", HREADYOUT); end
        checks++; if (PRESETn !== 1'b1) begin failures++; $display("FAIL rst_presetn_rel got=%b exp=1", PRESETn); end
    endtask

    task automatic test_single_read();
        PREADY = 2'b11; PSLVERR = 2'b00;
        HSEL = 2'b10; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 34'h0_1000_0004; HPROT = 4'b0011;
        #2;
        checks++; if (PSEL !== 2'b00) begin failures++; $display("FAIL rd_c0_psel got=%b exp=00", PSEL); end
        tick(); bus_idle(); #2;
        checks++; if (PSEL !== 2'b10) begin failures++; $display("FAIL rd_c1_psel got=%b exp=10", PSEL); end
        checks++; if (PENABLE !== 1'b0) begin failures++; $display("FAIL rd_c1_penable got=%b exp=0", PENABLE); end
        checks++; if (HREADYOUT !== 1'b0) begin failures++; $display("FAIL rd_c1_hreadyout got=%b exp=0", HREADYOUT); end
        checks++; if (PADDR !== 32'h1000_0004) begin failures++; $display("FAIL rd_c1_paddr got=%h exp=10000004", PADDR); end
        checks++; if (PPROT !== 3'b001) begin failures++; $display("FAIL rd_c1_pprot got=%b exp=001", PPROT); end
        tick(); #2;
        checks++; if (PSEL !== 2'b10) begin failures++; $display("FAIL rd_c2_psel got=%b exp=10", PSEL); end
        checks++; if (PENABLE !== 1'b1) begin failures++; $display("FAIL rd_c2_penable got=%b exp=1", PENABLE); end
        checks++; if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL rd_c2_hreadyout got=%b exp=1", HREADYOUT); end
        checks++; if (HRDATA !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_c2_hrdata got=%h exp=deadbeef", HRDATA); end
        checks++; if (HRESP !== 1'b0) begin failures++; $display("FAIL rd_c2_hresp got=%b exp=0", HRESP); end
        tick(); #2;
        checks++; if (PSEL !== 2'b00) begin failures++; $display("FAIL rd_c3_psel got=%b exp=00", PSEL); end
        checks++; if (HRDATA !== 32'h0) begin failures++; $display("FAIL rd_c3_hrdata got=%h exp=0", HRDATA); end
    endtask

    task automatic test_write_wait();
        PREADY = 2'b00; PSLVERR = 2'b00;
        HSEL = 2'b01; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 34'h0_1000_0100; HPROT = 4'b0000;
        tick(); bus_idle(); HWDATA = 32'h1234_5678; HWSTRB = 4'hF; #2;
        checks++; if (PSEL !== 2'b01) begin failures++; $display("FAIL wr_setup_psel got=%b exp=01", PSEL); end
        checks++; if (PPROT !== 3'b100) begin failures++; $display("FAIL wr_setup_pprot got=%b exp=100", PPROT); end
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 3) PREADY = 2'b01;
            #2;
            checks++; if (HREADYOUT !== (c == 3)) begin failures++; $display("FAIL wr_acc%0d_hreadyout got=%b exp=%b", c, HREADYOUT, (c == 3)); end
            checks++; if (PENABLE !== 1'b1) begin failures++; $display("FAIL wr_acc%0d_penable got=%b exp=1", c, PENABLE); end
            checks++; if ({PADDR, PWRITE, PWDATA, PSTRB} !== {32'h1000_0100, 1'b1, 32'h1234_5678, 4'hF}) begin
                failures++; $display("FAIL wr_acc%0d_stable got=%h/%b/%h/%h exp=10000100/1/12345678/f", c, PADDR, PWRITE, PWDATA, PSTRB);
            end
        end
        tick(); PREADY = 2'b00; #2;
        checks++; if (PSEL !== 2'b00) begin failures++; $display("FAIL wr_done_psel got=%b exp=00", PSEL); end
    endtask

    task automatic test_slverr();
        PREADY = 2'b00; PSLVERR = 2'b00;
        HSEL = 2'b01; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 34'h0_1000_0008;
        tick(); bus_idle(); #2;
        tick(); PREADY = 2'b01; PSLVERR = 2'b01; #2;
        checks++; if ({HRESP, HREADYOUT, PENABLE} !== 3'b101) begin failures++; $display("FAIL err_n got=%b exp=101", {HRESP, HREADYOUT, PENABLE}); end
        checks++; if (HRDATA !== 32'h0) begin failures++; $display("FAIL err_n_hrdata got=%h exp=0", HRDATA); end
        tick(); PREADY = 2'b00; PSLVERR = 2'b00; #2;
        checks++; if ({HRESP, HREADYOUT, PENABLE} !== 3'b110) begin failures++; $display("FAIL err_n1 got=%b exp=110", {HRESP, HREADYOUT, PENABLE}); end
        checks++; if (PSEL !== 2'b00) begin failures++; $display("FAIL err_n1_psel got=%b exp=00", PSEL); end
        tick(); #2;
        checks++; if ({HRESP, HREADYOUT} !== 2'b01) begin failures++; $display("FAIL err_idle got=%b exp=01", {HRESP, HREADYOUT}); end
    endtask

    task automatic test_timeout();
        PREADY = 2'b00; PSLVERR = 2'b00;
        HSEL = 2'b10; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 34'h0_1000_000C;
        tick(); bus_idle(); #2;
        for (int c = 0; c < 8; c++) begin
            tick(); #2;
            checks++; if (PENABLE !== 1'b1) begin failures++; $display("FAIL to_acc%0d_penable got=%b exp=1", c, PENABLE); end
            checks++; if ({HRESP, HREADYOUT} !== {(c == 7), 1'b0}) begin
                failures++; $display("FAIL to_acc%0d_resp got=%b exp=%b", c, {HRESP, HREADYOUT}, {(c == 7), 1'b0});
            end
        end
        tick(); #2;
        checks++; if ({HRESP, HREADYOUT, PENABLE, PSEL} !== 5'b11000) begin
            failures++; $display("FAIL to_err2 got=%b exp=11000", {HRESP, HREADYOUT, PENABLE, PSEL});
        end
        tick(); #2;
    endtask

    task automatic test_back_to_back();
        PREADY = 2'b11; PSLVERR = 2'b00;
        HSEL = 2'b01; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 34'h0_1000_0200;
        tick(); bus_idle(); HWDATA = 32'hAABB_CCDD; HWSTRB = 4'hF; #2;
        checks++; if ({PSEL, PWRITE, PENABLE} !== 4'b0110) begin failures++; $display("FAIL b2b_c1 got=%b exp=0110", {PSEL, PWRITE, PENABLE}); end
        tick(); HSEL = 2'b10; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 34'h0_1000_0300; #2;
        checks++; if ({PSEL, PENABLE, HREADYOUT} !== 4'b0111) begin failures++; $display("FAIL b2b_c2 got=%b exp=0111", {PSEL, PENABLE, HREADYOUT}); end
        tick(); bus_idle(); #2;
        checks++; if ({PSEL, PENABLE, PWRITE} !== 4'b1000) begin failures++; $display("FAIL b2b_c3 got=%b exp=1000", {PSEL, PENABLE, PWRITE}); end
        checks++; if (PADDR !== 32'h1000_0300) begin failures++; $display("FAIL b2b_c3_paddr got=%h exp=10000300", PADDR); end
        checks++; if (PSTRB !== 4'h0) begin failures++; $display("FAIL b2b_c3_pstrb got=%h exp=0", PSTRB); end
        tick(); #2;
        checks++; if ({PSEL, PENABLE, HREADYOUT} !== 4'b1011) begin failures++; $display("FAIL b2b_c4 got=%b exp=1011", {PSEL, PENABLE, HREADYOUT}); end
        checks++; if (HRDATA !== 32'hDEAD_BEEF) begin failures++; $display("FAIL b2b_c4_hrdata got=%h exp=deadbeef", HRDATA); end
        tick(); #2;
        checks++; if (PSEL !== 2'b00) begin failures++; $display("FAIL b2b_c5_psel got=%b exp=00", PSEL); end
    endtask

    task automatic test_reset_mid();
        PREADY = 2'b00; PSLVERR = 2'b00;
        HSEL = 2'b01; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 34'h0_1000_0400;
        tick(); bus_idle(); #2;
        tick(); reset = 1'b1; #2;
        checks++; if (PENABLE !== 1'b1) begin failures++; $display("FAIL rm_access_penable got=%b exp=1", PENABLE); end
        tick(); reset = 1'b0; HSEL = 2'b01; HTRANS = 2'b00; #2;
        checks++; if ({PSEL, PENABLE, PWRITE, HREADYOUT, HRESP} !== 6'b000010) begin
            failures++; $display("FAIL rm_after got=%b exp=000010", {PSEL, PENABLE, PWRITE, HREADYOUT, HRESP});
        end
        checks++; if (PADDR !== 32'h0) begin failures++; $display("FAIL rm_paddr got=%h exp=0", PADDR); end
        tick(); HTRANS = 2'b01; #2;
        checks++; if ({PSEL, HREADYOUT, HRESP} !== 4'b0010) begin failures++; $display("FAIL rm_idle_xfer got=%b exp=0010", {PSEL, HREADYOUT, HRESP}); end
        tick(); bus_idle(); #2;
        checks++; if ({PSEL, PENABLE} !== 3'b000) begin failures++; $display("FAIL rm_busy_xfer got=%b exp=000", {PSEL, PENABLE}); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
